// File: rtl/clint_rtc_tick_if.sv
// Bus port bundle for the CLINT real-time tick generator: one request strobe,
// a registered one-cycle acknowledge, and registered read data.
interface clint_rtc_tick_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/clint_rtc_tick.sv
// mtime tick generator: internal clk prescaler or synchronized external rt_clk
// rising edges, with a bus-visible tick counter.
module clint_rtc_tick #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          DIV_W   = 16,
  parameter int unsigned DIV_RST = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  clint_rtc_tick_if.slave      bus,
  input  logic                 rt_clk,
  output logic                 tick
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DIV    = 2'd1,
    REG_TCNT   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  reg_e              sel;
  logic              acc;
  logic              wr;
  logic              restart;
  logic              ext_edge;
  logic              div_hit;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bits;

  logic              en;
  logic              src;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  presc;
  logic [31:0]       tcnt;
  logic              sync1;
  logic              sync2;
  logic              hist;

  assign sel      = reg_e'(bus.address[3:2]);
  assign acc      = bus.valid & ~bus.ready;
  assign wr       = acc & (bus.wstrb == '1);
  assign restart  = wr & ((sel == REG_CTRL) | (sel == REG_DIV));
  assign ext_edge = sync2 & ~hist;
  assign div_hit  = (presc == div);
  assign unused_bits = ^{bus.address, bus.wdata};

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:   rd_mux = DATA_W'({src, en});
      REG_DIV:    rd_mux = DATA_W'(div);
      REG_TCNT:   rd_mux = DATA_W'(tcnt);
      REG_STATUS: rd_mux = DATA_W'(sync2);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= 1'b0;
      src       <= 1'b0;
      div       <= DIV_W'(DIV_RST);
      presc     <= '0;
      tcnt      <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hist      <= 1'b0;
      tick      <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      sync1     <= rt_clk;
      sync2     <= sync1;
      hist      <= sync2;
      bus.ready <= bus.valid & ~bus.ready;
      bus.rdata <= acc ? rd_mux : '0;

      if (wr && sel == REG_CTRL) begin
        en  <= bus.wdata[0];
        src <= bus.wdata[1];
      end
      if (wr && sel == REG_DIV)
        div <= bus.wdata[DIV_W-1:0];

      if (restart || !en || src)
        presc <= '0;
      else if (div_hit)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      // A CTRL/DIV write restarts the period, so no tick leaves on that edge.
      tick <= en & ~restart & (src ? ext_edge : div_hit);

      if (wr && sel == REG_TCNT)
        tcnt <= '0;
      else if (tick)
        tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clint_rtc_tick.sv
// Directed bench for clint_rtc_tick: register table plus timed sequences for
// prescaling, external edges, wrap/clear, bus hold-off and mid-count reset.
module tb_clint_rtc_tick;

  localparam int unsigned DIV_RST_TB = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rt_clk = 1'b0;
  logic tick;

  clint_rtc_tick_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  clint_rtc_tick #(
    .ADDR_W (32),
    .DATA_W (32),
    .DIV_W  (16),
    .DIV_RST(DIV_RST_TB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .rt_clk(rt_clk),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int ticks = 0;
  always @(negedge clk) if (tick) ticks <= ticks + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] r);
    bit got;
    got = 1'b0;
    r = '0;
    bus.valid = 1'b1; bus.address = a; bus.wdata = d; bus.wstrb = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) begin
        got = 1'b1;
        r = bus.rdata;
      end
    end
    bus.valid = 1'b0; bus.wstrb = '0;
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(a, 32'd0, 4'h0, r);
    check(name, r, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [31:0] r;
    int errs;
    int nrdy;
    int t0;

    vt[0]  = '{"rd_ctrl_rst",   32'h0,  32'h0,          4'h0, 1'b1, 32'h0};
    vt[1]  = '{"rd_div_rst",    32'h4,  32'h0,          4'h0, 1'b1, DIV_RST_TB};
    vt[2]  = '{"rd_tcnt_rst",   32'h8,  32'h0,          4'h0, 1'b1, 32'h0};
    vt[3]  = '{"rd_status_rst", 32'hC,  32'h0,          4'h0, 1'b1, 32'h0};
    vt[4]  = '{"wr_ctrl",       32'h0,  32'hFFFF_FFFE,  4'hF, 1'b0, 32'h0};
    vt[5]  = '{"rd_ctrl_mask",  32'h0,  32'h0,          4'h0, 1'b1, 32'h2};
    vt[6]  = '{"wr_div",        32'h4,  32'hABCD_1234,  4'hF, 1'b0, 32'h0};
    vt[7]  = '{"rd_div_zext",   32'h4,  32'h0,          4'h0, 1'b1, 32'h0000_1234};
    vt[8]  = '{"partial_strb",  32'h0,  32'h0000_0001,  4'h3, 1'b1, 32'h2};
    vt[9]  = '{"rd_ctrl_kept",  32'h0,  32'h0,          4'h0, 1'b1, 32'h2};
    vt[10] = '{"wr_status",     32'hC,  32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0};
    vt[11] = '{"rd_status_ro",  32'hC,  32'h0,          4'h0, 1'b1, 32'h0};
    vt[12] = '{"wr_ctrl_off",   32'h0,  32'h0,          4'hF, 1'b0, 32'h0};
    vt[13] = '{"rd_alias_ctrl", 32'h10, 32'h0,          4'h0, 1'b1, 32'h0};
    vt[14] = '{"rd_alias_div",  32'h14, 32'h0,          4'h0, 1'b1, 32'h0000_1234};

    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Register table (EN=0 throughout, so nothing ticks)
    t0 = ticks;
    foreach (vt[i]) begin
      bus_xfer(vt[i].addr, vt[i].wdata, vt[i].strb, r);
      if (vt[i].chk) check(vt[i].name, r, vt[i].exp);
    end
    check("table_no_tick", ticks - t0, 32'd0);

    // Internal divide by 5
    wr(32'h4, 32'd4);
    wr(32'h8, 32'd0);
    wr(32'h0, 32'h1);
    errs = (tick !== 1'b0) ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tick !== ((i % 5) == 0)) errs++;
    end
    check("div5_pattern_errs", errs, 32'd0);
    rd_chk("tcnt_in_tick_cycle", 32'h8, 32'd19);
    rd_chk("tcnt_after_20", 32'h8, 32'd20);
    wr(32'h0, 32'h0);

    // DIV=0: tick every cycle, then disable
    wr(32'h4, 32'd0);
    wr(32'h8, 32'd0);
    wr(32'h0, 32'h1);
    check("div0_write_cycle", {31'd0, tick}, 32'd0);
    errs = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick !== 1'b1) errs++;
    end
    check("div0_const_errs", errs, 32'd0);
    rd_chk("div0_tcnt_a", 32'h8, 32'd9);
    rd_chk("div0_tcnt_b", 32'h8, 32'd11);
    wr(32'h0, 32'h0);
    check("disable_tick", {31'd0, tick}, 32'd0);
    rd_chk("div0_tcnt_final", 32'h8, 32'd14);
    check("disabled_stays", {31'd0, tick}, 32'd0);

    // Wrap and clear-wins
    force dut.tcnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.tcnt;
    wr(32'h4, 32'd4);
    wr(32'h0, 32'h1);
    cycles(5);
    check("wrap_tick", {31'd0, tick}, 32'd1);
    rd_chk("tcnt_pre_wrap", 32'h8, 32'hFFFF_FFFF);
    rd_chk("tcnt_wrapped", 32'h8, 32'd0);
    cycles(2);
    check("clear_tick", {31'd0, tick}, 32'd1);
    wr(32'h8, 32'h1234_5678);
    rd_chk("clear_wins", 32'h8, 32'd0);
    wr(32'h0, 32'h0);

    // External rt_clk at 1/37 of clk
    wr(32'h8, 32'd0);
    wr(32'h0, 32'h3);
    errs = 0;
    for (int c = 0; c < 148; c++) begin
      @(negedge clk);
      if (tick !== ((c % 37) == 3)) errs++;
      rt_clk = ((c % 37) < 18);
    end
    check("ext_pattern_errs", errs, 32'd0);
    cycles(4);
    rd_chk("ext_tcnt", 32'h8, 32'd4);
    rt_clk = 1'b1;
    cycles(4);
    rd_chk("status_level", 32'hC, 32'd1);
    rt_clk = 1'b0;
    wr(32'h0, 32'h0);

    // Held valid with a non-write strobe
    @(negedge clk);
    nrdy = 0;
    bus.valid = 1'b1; bus.address = 32'h0; bus.wdata = 32'h3; bus.wstrb = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ready) nrdy++;
    end
    bus.valid = 1'b0; bus.wstrb = '0;
    check("held_ready_pulses", nrdy, 32'd2);
    rd_chk("held_ctrl_unchanged", 32'h0, 32'd0);

    // Reset mid-count: DIV=9, reset at prescaler=6
    wr(32'h4, 32'd9);
    wr(32'h0, 32'h1);
    cycles(10);
    check("div9_tick", {31'd0, tick}, 32'd1);
    cycles(6);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tick", {31'd0, tick}, 32'd0);
    reset = 1'b0;
    rd_chk("midrst_ctrl", 32'h0, 32'd0);
    rd_chk("midrst_tcnt", 32'h8, 32'd0);
    rd_chk("midrst_div", 32'h4, DIV_RST_TB);
    t0 = ticks;
    cycles(30);
    check("midrst_no_tick", ticks - t0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
